// File: rtl/a2d_intf.sv
// a2d_intf: round-robin ADC128S SPI front end for the left/right load cells, steering pot and battery.
// Optional build macro A2D_AVG_EN: each result is the rounded mean of the current and previous raw sample.
module a2d_intf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned RES_W  = 12;
    localparam int unsigned DIV_W  = 5;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned NUM_CH = 4;

    localparam logic [DIV_W-1:0] DIV_START = 5'b10111;
    localparam logic [DIV_W-1:0] DIV_RISE  = 5'b01111;
    localparam logic [DIV_W-1:0] DIV_FALL  = 5'b11111;
    localparam logic [DIV_W-1:0] DIV_LAST  = 5'b11110;
    localparam logic [CNT_W-1:0] NUM_RISES = 5'd16;

    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_GAP, ST_RD, ST_UPD} state_t;

    state_t                         state_q, state_d;
    logic [1:0]                     rr_q, rr_d;
    logic [DATA_W-1:0]              shft_q, shft_d;
    logic [DIV_W-1:0]               sdiv_q, sdiv_d;
    logic [CNT_W-1:0]               rise_cnt_q, rise_cnt_d;
    logic                           miso_smp_q, miso_smp_d;
    logic                           ss_n_q, ss_n_d;
    logic                           sclk_q, sclk_d;
    logic                           mosi_q, mosi_d;
    logic [NUM_CH-1:0][RES_W-1:0]   res_q, res_d;

    logic                           start_c, active_c, rise_c, fall_c, done_c;
    logic [2:0]                     ch_c;
    logic [DATA_W-1:0]              cmd_c;
    logic [RES_W-1:0]               upd_val_c;

    // Logical channel pointer to ADC channel number
    always_comb begin
        ch_c = 3'd0;
        case (rr_q)
            2'd0:    ch_c = 3'd0;
            2'd1:    ch_c = 3'd4;
            2'd2:    ch_c = 3'd5;
            default: ch_c = 3'd6;
        endcase
    end

    assign start_c  = ((state_q == ST_IDLE) && nxt) || (state_q == ST_GAP);
    assign cmd_c    = (state_q == ST_IDLE) ? {2'b00, ch_c, 11'h000} : 16'h0000;
    assign active_c = ~ss_n_q;
    assign rise_c   = active_c && (sdiv_q == DIV_RISE);
    assign fall_c   = active_c && (sdiv_q == DIV_FALL);
    // Last divider step before 11111 after the 16th rise closes the frame
    assign done_c   = active_c && (rise_cnt_q == NUM_RISES) && (sdiv_q == DIV_LAST);

`ifdef A2D_AVG_EN
    logic [NUM_CH-1:0][RES_W-1:0] prev_q, prev_d;
    logic [RES_W:0]               sum_c;

    always_comb begin
        prev_d    = prev_q;
        sum_c     = {1'b0, prev_q[rr_q]} + {1'b0, shft_q[RES_W-1:0]} + (RES_W+1)'(1);
        upd_val_c = sum_c[RES_W:1];
        if (state_q == ST_UPD) begin
            prev_d[rr_q] = shft_q[RES_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end
`else
    always_comb begin
        upd_val_c = shft_q[RES_W-1:0];
    end
`endif

    // SPI engine: divider, shift register, MISO sample flop, frame control
    always_comb begin
        sdiv_d     = sdiv_q;
        shft_d     = shft_q;
        rise_cnt_d = rise_cnt_q;
        miso_smp_d = miso_smp_q;
        ss_n_d     = ss_n_q;
        if (start_c) begin
            sdiv_d     = DIV_START;
            shft_d     = cmd_c;
            rise_cnt_d = '0;
            ss_n_d     = 1'b0;
        end else if (active_c) begin
            sdiv_d = sdiv_q + DIV_W'(1);
            if (rise_c) begin
                miso_smp_d = MISO;
                rise_cnt_d = rise_cnt_q + CNT_W'(1);
            end
            if ((fall_c && (rise_cnt_q != '0)) || done_c) begin
                shft_d = {shft_q[DATA_W-2:0], miso_smp_q};
            end
            if (done_c) begin
                ss_n_d = 1'b1;
            end
        end
        sclk_d = ss_n_d ? 1'b1 : sdiv_d[DIV_W-1];
        mosi_d = ss_n_d ? 1'b0 : shft_d[DATA_W-1];
    end

    // Conversion sequencer
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: if (nxt) state_d = ST_CMD;
            ST_CMD:  if (done_c) state_d = ST_GAP;
            ST_GAP:  state_d = ST_RD;
            ST_RD:   if (done_c) state_d = ST_UPD;
            ST_UPD: begin
                res_d[rr_q] = upd_val_c;
                rr_d        = rr_q + 2'd1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_q       <= '0;
            shft_q     <= '0;
            sdiv_q     <= '0;
            rise_cnt_q <= '0;
            miso_smp_q <= 1'b0;
            ss_n_q     <= 1'b1;
            sclk_q     <= 1'b1;
            mosi_q     <= 1'b0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            shft_q     <= shft_d;
            sdiv_q     <= sdiv_d;
            rise_cnt_q <= rise_cnt_d;
            miso_smp_q <= miso_smp_d;
            ss_n_q     <= ss_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            res_q      <= res_d;
        end
    end

    assign lft_ld    = res_q[0];
    assign rght_ld   = res_q[1];
    assign steer_pot = res_q[2];
    assign batt      = res_q[3];
    assign SS_n      = ss_n_q;
    assign SCLK      = sclk_q;
    assign MOSI      = mosi_q;

endmodule
